// File: rtl/gpio_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_link_pkg
// Description : Shared types and constants for the GPIO link scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_link_pkg;

    localparam int   MSG_W   = 128;
    localparam logic ROLE_RX = 1'b0;
    localparam logic ROLE_TX = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TURN     = 3'd1,
        ST_SEND_ARM = 3'd2,
        ST_SEND     = 3'd3,
        ST_DONE     = 3'd4
    } link_fsm_t;

endpackage
`default_nettype wire

// File: rtl/gpio_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : gpio_rr_pick
// Description : Combinational round-robin picker; search starts after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int   w_idx;
    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req[IDX_W'(w_idx)]) begin
                w_found                = 1'b1;
                grant[IDX_W'(w_idx)]   = 1'b1;
                grant_idx              = IDX_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpio_link_sched.sv
`default_nettype none
// ============================================================================
// Module      : gpio_link_sched
// Description : Round-robin TX scheduler and RX capture for the GPIO link.
//               Optional inbound capture enabled by GPIO_LINK_RX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_link_sched
    import gpio_link_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [MSG_W*NUM_REQ-1:0] req_msg,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       err,
    output logic                     busy,
    output logic                     link_state,
    output logic                     link_data_ready,
    output logic [MSG_W-1:0]         link_message_out,
    input  logic                     link_done,
    input  logic                     link_peer_ready,
    input  logic [MSG_W-1:0]         link_message_in,
    output logic                     rx_valid,
    output logic [MSG_W-1:0]         rx_msg
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_GW    = $clog2(GUARD + 1);
    localparam int c_TW    = $clog2(TIMEOUT + 1);
    localparam logic [c_GW-1:0] c_GUARD_LAST = c_GW'(GUARD - 1);
    localparam logic [c_TW-1:0] c_TO_LAST    = c_TW'(TIMEOUT - 1);

    link_fsm_t            r_state_q, w_state_d;
    logic [c_IDX_W-1:0]   r_ptr_q, w_ptr_d, r_win_idx_q, w_win_idx_d;
    logic [NUM_REQ-1:0]   r_win_oh_q, w_win_oh_d;
    logic [c_GW-1:0]      r_guard_q, w_guard_d;
    logic [c_TW-1:0]      r_to_q, w_to_d;
    logic                 r_link_state_q, w_link_state_d;
    logic                 r_data_ready_q, w_data_ready_d;
    logic [MSG_W-1:0]     r_msg_out_q, w_msg_out_d;
    logic [NUM_REQ-1:0]   r_ack_q, w_ack_d, r_err_q, w_err_d;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic [MSG_W-1:0]     w_msgs [NUM_REQ];
    logic                 w_rx_fire;
    logic                 w_start;

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_msg
        assign w_msgs[gi] = req_msg[gi*MSG_W +: MSG_W];
    end

    gpio_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_pick (
        .req       (req),
        .ptr       (r_ptr_q),
        .grant     (w_pick_oh),
        .grant_idx (w_pick_idx)
    );

    // An inbound message in the same cycle as a request takes precedence.
    assign w_start = (|req) & ~link_peer_ready & ~w_rx_fire;

    always_comb begin
        w_state_d      = r_state_q;
        w_ptr_d        = r_ptr_q;
        w_win_idx_d    = r_win_idx_q;
        w_win_oh_d     = r_win_oh_q;
        w_guard_d      = r_guard_q;
        w_to_d         = r_to_q;
        w_link_state_d = r_link_state_q;
        w_data_ready_d = r_data_ready_q;
        w_msg_out_d    = r_msg_out_q;
        w_ack_d        = '0;
        w_err_d        = '0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_start) begin
                    w_win_idx_d    = w_pick_idx;
                    w_win_oh_d     = w_pick_oh;
                    w_msg_out_d    = w_msgs[w_pick_idx];
                    w_link_state_d = ROLE_TX;
                    w_guard_d      = '0;
                    w_state_d      = ST_TURN;
                end
            end
            ST_TURN: begin
                if (r_guard_q == c_GUARD_LAST) begin
                    w_data_ready_d = 1'b1;
                    w_to_d         = '0;
                    w_state_d      = ST_SEND_ARM;
                end else begin
                    w_guard_d = r_guard_q + 1'b1;
                end
            end
            ST_SEND_ARM, ST_SEND: begin
                w_to_d = r_to_q + 1'b1;
                if ((r_state_q == ST_SEND) && link_done) begin
                    w_data_ready_d = 1'b0;
                    w_ack_d        = r_win_oh_q;
                    w_ptr_d        = r_win_idx_q;
                    w_state_d      = ST_DONE;
                end else if (r_to_q == c_TO_LAST) begin
                    w_data_ready_d = 1'b0;
                    w_err_d        = r_win_oh_q;
                    w_ptr_d        = r_win_idx_q;
                    w_state_d      = ST_DONE;
                end else if ((r_state_q == ST_SEND_ARM) && !link_done) begin
                    w_state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                w_link_state_d = ROLE_RX;
                w_state_d      = ST_IDLE;
            end
            default: begin
                w_link_state_d = ROLE_RX;
                w_data_ready_d = 1'b0;
                w_state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state_q      <= ST_IDLE;
            r_ptr_q        <= c_IDX_W'(NUM_REQ - 1);
            r_win_idx_q    <= '0;
            r_win_oh_q     <= '0;
            r_guard_q      <= '0;
            r_to_q         <= '0;
            r_link_state_q <= ROLE_RX;
            r_data_ready_q <= 1'b0;
            r_msg_out_q    <= '0;
            r_ack_q        <= '0;
            r_err_q        <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_ptr_q        <= w_ptr_d;
            r_win_idx_q    <= w_win_idx_d;
            r_win_oh_q     <= w_win_oh_d;
            r_guard_q      <= w_guard_d;
            r_to_q         <= w_to_d;
            r_link_state_q <= w_link_state_d;
            r_data_ready_q <= w_data_ready_d;
            r_msg_out_q    <= w_msg_out_d;
            r_ack_q        <= w_ack_d;
            r_err_q        <= w_err_d;
        end
    end

`ifdef GPIO_LINK_RX_EN
    logic             r_peer_prev_q;
    logic             r_rx_valid_q;
    logic [MSG_W-1:0] r_rx_msg_q, w_rx_msg_d;

    assign w_rx_fire = (r_state_q == ST_IDLE) & r_peer_prev_q & ~link_peer_ready;

    always_comb begin
        w_rx_msg_d = r_rx_msg_q;
        if (w_rx_fire) begin
            w_rx_msg_d = link_message_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_peer_prev_q <= 1'b0;
            r_rx_valid_q  <= 1'b0;
            r_rx_msg_q    <= '0;
        end else begin
            r_peer_prev_q <= link_peer_ready;
            r_rx_valid_q  <= w_rx_fire;
            r_rx_msg_q    <= w_rx_msg_d;
        end
    end

    assign rx_valid = r_rx_valid_q;
    assign rx_msg   = r_rx_msg_q;
`else
    logic w_unused_rx;

    assign w_unused_rx = ^link_message_in;
    assign w_rx_fire   = 1'b0;
    assign rx_valid    = 1'b0;
    assign rx_msg      = '0;
`endif

    assign ack              = r_ack_q;
    assign err              = r_err_q;
    assign busy             = (r_state_q != ST_IDLE);
    assign link_state       = r_link_state_q;
    assign link_data_ready  = r_data_ready_q;
    assign link_message_out = r_msg_out_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_link_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_link_sched
// Description : Randomized self-checking bench for gpio_link_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_link_sched;

    localparam int N       = 4;
    localparam int GUARD   = 2;
    localparam int TIMEOUT = 1023;

    logic             clock;
    logic             resetn;
    logic [N-1:0]     req;
    logic [N*128-1:0] req_msg;
    logic [N-1:0]     ack;
    logic [N-1:0]     err;
    logic             busy;
    logic             link_state;
    logic             link_data_ready;
    logic [127:0]     link_message_out;
    logic             link_done;
    logic             link_peer_ready;
    logic [127:0]     link_message_in;
    logic             rx_valid;
    logic [127:0]     rx_msg;

    logic [127:0] msgs [N];
    int           ptr_m;
    int           n_checks;
    int           n_pass;

    gpio_link_sched #(
        .NUM_REQ (N),
        .GUARD   (GUARD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .req              (req),
        .req_msg          (req_msg),
        .ack              (ack),
        .err              (err),
        .busy             (busy),
        .link_state       (link_state),
        .link_data_ready  (link_data_ready),
        .link_message_out (link_message_out),
        .link_done        (link_done),
        .link_peer_ready  (link_peer_ready),
        .link_message_in  (link_message_in),
        .rx_valid         (rx_valid),
        .rx_msg           (rx_msg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Round-robin reference: first requester after the last winner.
    function automatic int model_pick(input logic [N-1:0] m);
        for (int s = 1; s <= N; s++) begin
            if (m[(ptr_m + s) % N]) return (ptr_m + s) % N;
        end
        return -1;
    endfunction

    task automatic new_msgs();
        for (int i = 0; i < N; i++) begin
            msgs[i]      = {$urandom, $urandom, $urandom, $urandom};
            msgs[i][3:0] = 4'(i);
        end
    endtask

    task automatic pack_msgs();
        for (int i = 0; i < N; i++) req_msg[i*128 +: 128] = msgs[i];
    endtask

    // Runs a granted transfer from just after the grant edge to IDLE.
    task automatic xfer_body(input int win, input bit drop_mid, input bit to_mode);
        logic [N-1:0] oh;
        int           waited;
        oh = N'(1) << win;
        check_val("grant_msg", link_message_out, msgs[win]);
        check_val("grant_busy", busy, 1'b1);
        if (drop_mid) req = '0;
        for (int k = 1; k <= GUARD; k++) begin
            cyc();
            check_val("guard_dr", link_data_ready, (k == GUARD));
        end
        if (!to_mode) begin
            link_done = 1'b0;
            repeat ($urandom_range(1, 4)) cyc();
            check_val("arm_no_ack", ack, '0);
            check_val("arm_dr", link_data_ready, 1'b1);
            link_done = 1'b1;
            cyc();
            check_val("ack", ack, oh);
            check_val("ack_err", err, '0);
            check_val("ack_dr", link_data_ready, 1'b0);
            check_val("ack_state", link_state, 1'b1);
        end else begin
            waited = 0;
            while (err == '0 && waited < TIMEOUT + 8) begin
                cyc();
                waited++;
            end
            check_val("to_cycles", waited, TIMEOUT);
            check_val("to_err", err, oh);
            check_val("to_ack", ack, '0);
            check_val("to_dr", link_data_ready, 1'b0);
        end
        ptr_m = win;
        req   = '0;
        cyc();
        check_val("pulse_end", ack | err, '0);
        check_val("idle_state", link_state, 1'b0);
        check_val("idle_busy", busy, 1'b0);
    endtask

    task automatic run_xfer(input logic [N-1:0] mask, input bit drop_mid, input bit to_mode);
        int win;
        pack_msgs();
        win       = model_pick(mask);
        link_done = 1'b1;
        req       = mask;
        cyc();
        check_val("grant_state", link_state, 1'b1);
        xfer_body(win, drop_mid, to_mode);
    endtask

    task automatic rx_test(input logic [127:0] m, input logic [N-1:0] mask);
        int win;
        new_msgs();
        pack_msgs();
        win             = model_pick(mask);
        link_done       = 1'b1;
        link_peer_ready = 1'b1;
        req             = mask;
        repeat (3) cyc();
        check_val("rx_block_state", link_state, 1'b0);
        check_val("rx_block_busy", busy, 1'b0);
        link_peer_ready = 1'b0;
        link_message_in = m;
        cyc();
`ifdef GPIO_LINK_RX_EN
        check_val("rx_valid", rx_valid, 1'b1);
        check_val("rx_msg", rx_msg, m);
        check_val("rx_wins", link_state, 1'b0);
        cyc();
        check_val("rx_valid_end", rx_valid, 1'b0);
`else
        check_val("rx_valid_off", rx_valid, 1'b0);
        check_val("rx_msg_off", rx_msg, '0);
`endif
        check_val("rx_then_grant", link_state, 1'b1);
        xfer_body(win, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        resetn          = 1'b0;
        req             = '0;
        req_msg         = '0;
        link_done       = 1'b0;
        link_peer_ready = 1'b0;
        link_message_in = '0;
        ptr_m           = N - 1;
        repeat (2) @(negedge clock);
        check_val("rst_state", link_state, 1'b0);
        check_val("rst_dr", link_data_ready, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_ackerr", {ack, err}, '0);
        check_val("rst_msg", link_message_out, '0);
        check_val("rst_rx", {rx_valid, rx_msg}, '0);
        resetn = 1'b1;
        cyc();

        // Single request with a fixed pattern
        new_msgs();
        msgs[2] = {16{8'hA5}};
        run_xfer(4'b0100, 1'b0, 1'b0);

        // Fairness with all requesters active
        for (int t = 0; t < 5; t++) begin
            new_msgs();
            run_xfer(4'b1111, 1'b0, 1'b0);
        end

        // Stale done held high through the whole transfer
        new_msgs();
        run_xfer(N'($urandom_range(1, 15)), 1'b0, 1'b1);

        rx_test(128'h1234, 4'b0001);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                rx_test({$urandom, $urandom, $urandom, $urandom}, N'($urandom_range(1, 15)));
            end else begin
                new_msgs();
                run_xfer(N'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0), 1'b0);
            end
        end

        // Reset while in SEND
        new_msgs();
        pack_msgs();
        link_done = 1'b1;
        req       = 4'b1111;
        cyc();
        repeat (GUARD) cyc();
        link_done = 1'b0;
        repeat (3) cyc();
        #2 resetn = 1'b0;
        #1;
        check_val("arst_state", link_state, 1'b0);
        check_val("arst_dr", link_data_ready, 1'b0);
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_ackerr", {ack, err}, '0);
        check_val("arst_msg", link_message_out, '0);
        req = '0;
        @(negedge clock);
        resetn = 1'b1;
        ptr_m  = N - 1;
        cyc();
        check_val("arst_no_pulse", {ack, err}, '0);
        new_msgs();
        run_xfer(4'b1111, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_link_sched.md
# gpio_link_sched

Transmit scheduler and receive capture controller for the 128-bit GPIO board-to-board link. Up to NUM_REQ local requesters each present a 128-bit message; the block arbitrates round-robin, switches the link into the transmit role, drives `data_ready`, and watches `done` with a timeout. When idle it holds the link in the receive role and captures inbound messages. It sits between the application logic and `gpio_protocol`, and is the only block that drives that instance's `state`, `data_ready` and `message_out`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GUARD`, 2: cycles `link_state` is held at 1 before `data_ready` rises (role turnaround).
- `TIMEOUT`, 1023: maximum cycles in SEND before the transfer is aborted.
- `clock` in 1: single clock for all logic.
- `resetn` in 1: asynchronous active-low reset.
- `req` in NUM_REQ: level request per requester; held until `ack` or `err` for that requester.
- `req_msg` in 128*NUM_REQ: message of requester i is at bits [128*i+127:128*i]; stable while `req[i]` is high.
- `ack` out NUM_REQ: one-cycle one-hot pulse when the granted message completes.
- `err` out NUM_REQ: one-cycle one-hot pulse when the granted message times out.
- `busy` out 1: high in every state except IDLE.
- `link_state` out 1: to `gpio_protocol.state`; 1 = transmit role.
- `link_data_ready` out 1: to `gpio_protocol.data_ready`.
- `link_message_out` out 128: to `gpio_protocol.message_out`.
- `link_done` in 1: from `gpio_protocol.done`.
- `link_peer_ready` in 1: remote ready level, as seen in the receive role.
- `link_message_in` in 128: from `gpio_protocol.message_in`.
- `rx_valid` out 1: one-cycle pulse when `rx_msg` has been updated.
- `rx_msg` out 128: last captured inbound message.

## Operation
- FSM states: IDLE, TURN, SEND_ARM, SEND, DONE.
- IDLE: `link_state`=0 and `link_data_ready`=0.
  - Leave IDLE only when `|req` is high and `link_peer_ready`=0.
  - On that edge: register the round-robin winner, load `link_message_out` with its `req_msg`, set `link_state`=1, and go to TURN.
- Round-robin: search begins at (last winner + 1) mod NUM_REQ. The pointer resets to NUM_REQ-1, so requester 0 has priority first.
- TURN: count GUARD cycles, then set `link_data_ready`=1 and go to SEND_ARM.
- SEND_ARM: `done` is stale at entry. Wait for `link_done`=0, then go to SEND.
- SEND: wait for `link_done`=1.
  - On that edge: set `link_data_ready`=0, pulse `ack[winner]`, advance the pointer, and go to DONE.
- DONE: one cycle. `link_state` returns to 0, then go to IDLE.
- Timeout: one counter, log2(TIMEOUT+1) bits wide, cleared on entering SEND_ARM and counting in SEND_ARM and SEND.
  - When the count reaches TIMEOUT, set `link_data_ready`=0, pulse `err[winner]`, advance the pointer, and go to DONE.
- If `req[winner]` drops mid-transfer, the transfer still completes; `ack` is still pulsed.
- `link_message_out` holds its value until the next grant.

## Timing
- Reset values: all outputs 0; FSM in IDLE; pointer NUM_REQ-1; timeout counter 0.
- Request seen in IDLE at edge N:
  - `link_state`=1 from edge N+1.
  - `link_data_ready`=1 from edge N+1+GUARD.
- `link_done` rising sampled at edge M: `ack` and `link_data_ready`=0 at edge M+1; `link_state`=0 at edge M+2; a new grant is possible at edge M+3.
- Simultaneous RX and TX in IDLE: RX wins. No grant while `link_peer_ready`=1.
- Reset asserted mid-transfer: `link_data_ready` and `link_state` fall immediately, asynchronously. No `ack` or `err` is issued.

## Configuration
- `GPIO_LINK_RX_EN` defined:
  - In IDLE, a falling edge on `link_peer_ready` (registered previous value 1, current value 0) captures `link_message_in` into `rx_msg` and pulses `rx_valid` on the next edge.
- `GPIO_LINK_RX_EN` undefined:
  - No capture register; `rx_msg` and `rx_valid` are tied to 0.
  - `link_peer_ready` still blocks grants.

## Structure
- Package `gpio_link_pkg` holds:
  - the FSM state enum;
  - `MSG_W`=128;
  - the role constants `ROLE_RX`=0 and `ROLE_TX`=1.
- Sub-module `gpio_rr_pick`: combinational round-robin picker. Inputs are `req` and the pointer; outputs are the one-hot winner and its index. Parameterised on NUM_REQ.

## Test plan
- Single request: reset, then `req`=4'b0100 with message 128'hA5…A5 → `link_message_out`=A5…A5, `link_state` rises, `link_data_ready` rises GUARD cycles later. Drive `done` 1→0→1 → `ack`=4'b0100 for one cycle, FSM back to IDLE.
- Fairness: `req`=4'b1111 held, each transfer completed → grant order 0,1,2,3,0; exactly one `ack` bit per transfer.
- Stale done: `link_done` stuck at 1 from the grant → no `ack`. After TIMEOUT cycles → `err[winner]` pulse, `link_data_ready`=0.
- RX priority: `link_peer_ready`=1 and `req`=4'b0001 → no grant. Then `link_peer_ready` falls with `link_message_in`=128'h1234 → `rx_valid` pulse, `rx_msg`=128'h1234, grant follows. With `GPIO_LINK_RX_EN` undefined → `rx_valid` stays 0.
- Reset mid-SEND → all outputs 0 asynchronously; after release, the first grant goes to requester 0.
